multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/minimips_ctrl_pkg.sv | 55 +++++
 rtl/mc_ctrl_decode.sv | 66 ++++++
 rtl/multicycle_control.sv | 123 ++++++++++++
 tb/tb_multicycle_control.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minimips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS-style controller:
// FSM state encoding, opcode map and ALUOp selections.
package minimips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_ANDI  = 4'h2;
    localparam logic [3:0] OP_ORI   = 4'h3;
    localparam logic [3:0] OP_SLTI  = 4'h4;
    localparam logic [3:0] OP_LW    = 4'h5;
    localparam logic [3:0] OP_SW    = 4'h6;
    localparam logic [3:0] OP_BEQ   = 4'h7;
    localparam logic [3:0] OP_BNE   = 4'h8;

    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b101;

    // Opcode arrives zero-extended to 8 bits so any set bit above bit 3 is illegal.
    function automatic logic op_legal(input logic [7:0] op);
        return op <= {4'h0, OP_BNE};
    endfunction

    function automatic logic op_is_branch(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic op_is_mem(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_ADDI, OP_LW, OP_SW: return ALU_ADD;
            OP_ANDI:               return ALU_AND;
            OP_ORI:                return ALU_OR;
            OP_SLTI:               return ALU_SLT;
            OP_BEQ, OP_BNE:        return ALU_SUB;
            default:               return ALU_RTYPE;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode from (state, latched opcode). Strobes that must
// wait for memory completion are returned raw and qualified by the top.
module mc_ctrl_decode
    import minimips_ctrl_pkg::*;
(
    input  logic [2:0] state,
    input  logic [3:0] op,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       branch,
    output logic [2:0] alu_op,
    output logic       done_now,
    output logic       done_on_ready
);

    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        branch        = 1'b0;
        alu_op        = ALU_RTYPE;
        done_now      = 1'b0;
        done_on_ready = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                pc_write = 1'b1;
                ir_write = 1'b1;
            end
            S_EXEC: begin
                alu_op  = alu_op_of(op);
                alu_src = !((op == OP_RTYPE) || op_is_branch(op));
                if (op_is_branch(op)) begin
                    branch   = 1'b1;
                    done_now = 1'b1;
                end
            end
            S_MEM: begin
                alu_op        = alu_op_of(op);
                mem_read      = (op == OP_LW);
                mem_write     = (op == OP_SW);
                done_on_ready = (op == OP_SW);
            end
            S_WB: begin
                alu_op     = alu_op_of(op);
                reg_write  = 1'b1;
                done_now   = 1'b1;
                reg_dst    = (op == OP_RTYPE);
                mem_to_reg = (op == OP_LW);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB) with optional
// performance counters enabled by defining MULTICYCLE_CONTROL_PERF_EN.
module multicycle_control
    import minimips_ctrl_pkg::*;
#(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   Opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic [2:0]       ALUOp,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [2:0]       state
`ifdef MULTICYCLE_CONTROL_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    if (OPW < 4 || OPW > 8 || CNT_W < 1) begin : g_param_check
        $error("multicycle_control: OPW must be 4..8 and CNT_W at least 1");
    end

    state_t     state_reg;
    logic [3:0] opcode_reg;
    logic [7:0] opcode_ext;
    logic       legal;

    always_comb begin
        opcode_ext          = '0;
        opcode_ext[OPW-1:0] = Opcode;
    end

    assign legal = op_legal(opcode_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            opcode_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE:   state_reg <= S_FETCH;
                S_FETCH:  if (mem_ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    opcode_reg <= opcode_ext[3:0];
                    state_reg  <= legal ? S_EXEC : S_FETCH;
                end
                S_EXEC: begin
                    if (op_is_branch(opcode_reg))   state_reg <= S_FETCH;
                    else if (op_is_mem(opcode_reg)) state_reg <= S_MEM;
                    else                            state_reg <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready) state_reg <= (opcode_reg == OP_SW) ? S_FETCH : S_WB;
                end
                S_WB:     state_reg <= S_FETCH;
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

    logic dec_pc_write, dec_ir_write, dec_done_now, dec_done_on_ready;

    mc_ctrl_decode u_decode (
        .state         (state_reg),
        .op            (opcode_reg),
        .pc_write      (dec_pc_write),
        .ir_write      (dec_ir_write),
        .reg_dst       (RegDst),
        .alu_src       (ALUSrc),
        .mem_to_reg    (MemtoReg),
        .reg_write     (RegWrite),
        .mem_read      (MemRead),
        .mem_write     (MemWrite),
        .branch        (Branch),
        .alu_op        (ALUOp),
        .done_now      (dec_done_now),
        .done_on_ready (dec_done_on_ready)
    );

    // IR/PC load and SW completion happen only in the cycle the access finishes.
    assign PCWrite    = dec_pc_write & mem_ready;
    assign IRWrite    = dec_ir_write & mem_ready;
    assign instr_done = dec_done_now | (dec_done_on_ready & mem_ready);
    assign illegal_op = (state_reg == S_DECODE) & !legal;
    assign state      = state_reg;

`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [CNT_W-1:0] instr_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             stall;

    assign stall = ((state_reg == S_FETCH) || (state_reg == S_MEM)) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (instr_done && !(&instr_cnt_reg)) instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
            if (stall && !(&stall_cnt_reg))      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign instr_count = instr_cnt_reg;
    assign stall_count = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: random instruction stream against a
// per-instruction behavioural model; covers counters when MULTICYCLE_CONTROL_PERF_EN is set.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int OPW = 4;
`ifdef MULTICYCLE_CONTROL_PERF_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif
    localparam int N_RAND = 40;

    typedef struct {
        int op;
        int f;
        int m;
        int lat;
        int illegal;
        int is_mem;
        int n_rw;
        int rdst;
        int m2r;
        int n_mr;
        int n_mw;
        int n_br;
        int alu;
        int asrc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [OPW-1:0] Opcode = '0;
    logic           mem_ready = 1'b0;
    logic           PCWrite, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrite;
    logic           MemRead, MemWrite, Branch, instr_done, illegal_op;
    logic [2:0]     ALUOp, state;
`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [CW-1:0]  instr_count, stall_count;
`endif

    exp_t exp_q[$];
    int   n_err = 0;
    int   n_checks = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    multicycle_control #(.OPW(OPW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .ALUOp      (ALUOp),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
`ifdef MULTICYCLE_CONTROL_PERF_EN
        ,
        .instr_count(instr_count),
        .stall_count(stall_count)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int alu_of(input int op);
        case (op)
            1, 5, 6: return 1;
            2:       return 2;
            3:       return 3;
            4:       return 4;
            7, 8:    return 5;
            default: return 0;
        endcase
    endfunction

    // Expected per-instruction behaviour from the opcode map and latency rules.
    function automatic exp_t model(input int op, input int f, input int m);
        exp_t e;
        int   br, lw, sw;
        br = (op == 7 || op == 8) ? 1 : 0;
        lw = (op == 5) ? 1 : 0;
        sw = (op == 6) ? 1 : 0;
        e.op      = op;
        e.f       = f;
        e.is_mem  = lw | sw;
        e.m       = e.is_mem ? m : 0;
        e.illegal = (op > 8) ? 1 : 0;
        if (e.illegal == 1)  e.lat = f + 2;
        else if (br == 1)    e.lat = f + 3;
        else if (lw == 1)    e.lat = f + 5 + e.m;
        else                 e.lat = f + 4 + e.m;
        e.n_rw = (e.illegal == 0 && br == 0 && sw == 0) ? 1 : 0;
        e.rdst = (op == 0) ? 1 : 0;
        e.m2r  = lw;
        e.n_mr = f + 1 + (lw == 1 ? e.m + 1 : 0);
        e.n_mw = (sw == 1) ? e.m + 1 : 0;
        e.n_br = (e.illegal == 0) ? br : 0;
        e.alu  = alu_of(op);
        e.asrc = (op >= 1 && op <= 6) ? 1 : 0;
        return e;
    endfunction

    function automatic int exp_state(input exp_t e, input int k);
        if (k <= e.f)                             return 1;
        if (k == e.f + 1)                         return 2;
        if (k == e.f + 2)                         return 3;
        if (e.is_mem == 1 && k <= e.f + 3 + e.m)  return 4;
        return 5;
    endfunction

    // Drives one instruction's cycle stream; inputs change 1ns after each rising edge.
    task automatic run_instr(input int op, input int f, input int m);
        exp_t e;
        logic r;
        e = model(op, f, m);
        exp_q.push_back(e);
        for (int k = 0; k < e.lat; k++) begin
            r = 1'($urandom_range(0, 1));
            if (k < f)                                               r = 1'b0;
            else if (k == f)                                         r = 1'b1;
            else if (e.is_mem == 1 && k >= f + 3 && k < f + 3 + e.m) r = 1'b0;
            else if (e.is_mem == 1 && k == f + 3 + e.m)              r = 1'b1;
            mem_ready = r;
            Opcode    = (k == f + 1) ? OPW'(op) : OPW'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        exp_t cur;
        int k = 0, txn = 0, e0;
        int c_rw = 0, c_mr = 0, c_mw = 0, c_br = 0, c_pcw = 0, c_irw = 0;
        int c_done = 0, c_ill = 0, c_both = 0, st_bad = 0, alu_early = 0;
        int alu_x = 0, asrc_x = 0, rdst_x = 0, m2r_x = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            if (exp_q.size() == 0) begin
                if (instr_done || illegal_op) check("unexpected_end", 1, 0);
                continue;
            end
            cur = exp_q[0];
            c_rw   += int'(RegWrite);
            c_mr   += int'(MemRead);
            c_mw   += int'(MemWrite);
            c_br   += int'(Branch);
            c_pcw  += int'(PCWrite);
            c_irw  += int'(IRWrite);
            c_done += int'(instr_done);
            c_ill  += int'(illegal_op);
            if (MemRead && MemWrite) c_both++;
            if (RegWrite) begin
                rdst_x = int'(RegDst);
                m2r_x  = int'(MemtoReg);
            end
            if (k <= cur.f + 1 && ALUOp != 3'b000) alu_early++;
            if (k == cur.f + 2) begin
                alu_x  = int'(ALUOp);
                asrc_x = int'(ALUSrc);
            end
            if (int'(state) != exp_state(cur, k)) st_bad++;
            if (instr_done || illegal_op || k >= cur.lat - 1) begin
                e0 = n_err;
                check("end_cycle", k, cur.lat - 1);
                check("instr_done_count", c_done, 1 - cur.illegal);
                check("illegal_op_count", c_ill, cur.illegal);
                check("state_trace_mismatches", st_bad, 0);
                check("regwrite_cycles", c_rw, cur.n_rw);
                check("memread_cycles", c_mr, cur.n_mr);
                check("memwrite_cycles", c_mw, cur.n_mw);
                check("branch_cycles", c_br, cur.n_br);
                check("pcwrite_cycles", c_pcw, 1);
                check("irwrite_cycles", c_irw, 1);
                check("memread_and_memwrite", c_both, 0);
                check("aluop_nonzero_fetch_decode", alu_early, 0);
                if (cur.n_rw == 1) begin
                    check("regdst_in_wb", rdst_x, cur.rdst);
                    check("memtoreg_in_wb", m2r_x, cur.m2r);
                end
                if (cur.illegal == 0) begin
                    check("aluop_in_exec", alu_x, cur.alu);
                    check("alusrc_in_exec", asrc_x, cur.asrc);
                end
                $display("txn %0d op=%0d fetch_wait=%0d mem_wait=%0d cycles=%0d errors=%0d",
                         txn, cur.op, cur.f, cur.m, k + 1, n_err - e0);
                void'(exp_q.pop_front());
                txn++;
                k = 0;
                c_rw = 0; c_mr = 0; c_mw = 0; c_br = 0; c_pcw = 0; c_irw = 0;
                c_done = 0; c_ill = 0; c_both = 0; st_bad = 0; alu_early = 0;
                alu_x = 0; asrc_x = 0; rdst_x = 0; m2r_x = 0;
            end else begin
                k++;
            end
        end
    endtask

    function automatic int outs_vec();
        return int'({PCWrite, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead,
                     MemWrite, Branch, ALUOp, instr_done, illegal_op});
    endfunction

    int dir_op[6] = '{0, 5, 7, 10, 6, 0};
    int dir_f[6]  = '{0, 0, 0, 0, 1, 2};
    int dir_m[6]  = '{0, 2, 0, 0, 1, 0};

    initial begin
        int legal_cnt, stall_sum, sat, op, f, m;
        legal_cnt = 0;
        stall_sum = 0;
        sat = (1 << CW) - 1;
        fork
            monitor();
        join_none

        // Reset held across edges with inputs that would otherwise act.
        mem_ready = 1'b1;
        Opcode    = OPW'(6);
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'(state), 0);
        check("reset_outputs", outs_vec(), 0);
`ifdef MULTICYCLE_CONTROL_PERF_EN
        check("reset_instr_count", int'(instr_count), 0);
        check("reset_stall_count", int'(stall_count), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_after_release", int'(state), 0);
        check("idle_outputs", outs_vec(), 0);
        @(posedge clk);
        #1;
        check("first_edge_fetch", int'(state), 1);

        mon_en = 1'b1;
        for (int i = 0; i < 6 + N_RAND; i++) begin
            if (i < 6) begin
                op = dir_op[i];
                f  = dir_f[i];
                m  = dir_m[i];
            end else begin
                op = $urandom_range(0, 15);
                f  = $urandom_range(0, 2);
                m  = $urandom_range(0, 3);
            end
            if (op <= 8) legal_cnt++;
            stall_sum += f + ((op == 5 || op == 6) ? m : 0);
            run_instr(op, f, m);
        end
        mon_en = 1'b0;
        mem_ready = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);
`ifdef MULTICYCLE_CONTROL_PERF_EN
        check("instr_count_saturated", int'(instr_count), (legal_cnt < sat) ? legal_cnt : sat);
        check("stall_count_saturated", int'(stall_count), (stall_sum < sat) ? stall_sum : sat);
`endif

        // Reset asserted mid-way through a stalled SW memory access.
        mem_ready = 1'b1;
        Opcode    = OPW'(6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("sw_mem_state", int'(state), 4);
        check("sw_memwrite", int'(MemWrite), 1);
        @(posedge clk); #1;
        check("sw_memwrite_stalled", int'(MemWrite), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_memwrite", int'(MemWrite), 0);
        check("async_reset_state", int'(state), 0);
        check("async_reset_outputs", outs_vec(), 0);
`ifdef MULTICYCLE_CONTROL_PERF_EN
        check("async_reset_instr_count", int'(instr_count), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_fetch", int'(state), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
